sd_dat_in_pio: RTL and testbench
================================

// Module: sd_dat_in_pio
// PURPOSE
//   Avalon-MM input PIO for the SD-card data/response lines (SD_DAT[3:0]/SD_CMD read-back).
//   It is the read-side companion of the bit-banged SD clock/command output PIOs.
//   Synchronises asynchronous pad inputs, detects edges, latches them in a sticky
//   edge-capture register and raises a maskable level interrupt to the Nios II.
// PARAMETERS
//   WIDTH        4   number of input bits (1..32)
//   EDGE_TYPE    0   0 = rising, 1 = falling, 2 = any edge captured
//   SYNC_STAGES  2   synchroniser flops per input bit (2..4)
// PORTS
//   clk          in   1      system clock
//   reset_n      in   1      reset, asynchronous assert, active-low
//   address      in   2      word address: 0 data, 2 irq mask, 3 edge capture
//   chipselect   in   1      slave select
//   write_n      in   1      active-low write strobe (valid with chipselect)
//   writedata    in   32     write data; bits above WIDTH-1 ignored
//   in_port      in   WIDTH  asynchronous pad inputs
//   readdata     out  32     registered read data; bits above WIDTH-1 read 0
//   irq          out  1      level interrupt, active-high
// BEHAVIOUR
//   Reset: sync chain, prev, irq_mask, edge_capture, readdata, prime counter = 0; irq = 0.
//   Synchroniser: SYNC_STAGES-deep flop chain per bit; s = last stage; prev = s delayed 1 clk.
//   Prime counter: counts 0..SYNC_STAGES+1 after reset, then saturates.
//     Edge detection is disabled until saturated; no false edge after reset while the input is high.
//   Edge detect per bit:
//     rise = s & ~prev; fall = ~s & prev; any = s ^ prev. EDGE_TYPE selects which signal is used.
//   Latency: in_port change -> edge_capture bit set after SYNC_STAGES+1 clks (3 at default).
//   Write (chipselect & ~write_n), takes effect on the next clk edge:
//     addr 2: irq_mask <= writedata[WIDTH-1:0].
//     addr 3: write-1-to-clear; edge_capture <= (edge_capture & ~wd) | det.
//     addr 0/1: ignored; no state change.
//   Simultaneous clear and new edge on the same bit: the edge wins and the bit stays 1.
//   Edge on an already-set bit: the bit stays 1. No counting and no overflow.
//   Read: readdata is registered every clk from the mux on address (chipselect not required).
//     Read latency is 1 clk.
//     addr 0 = s (synchronised value), addr 1 = 0, addr 2 = irq_mask, addr 3 = edge_capture.
//   irq = |(edge_capture & irq_mask), driven from registers only. Asserts 1 clk after the capture bit sets.
//     Deasserts 1 clk after the clearing write or after the mask write that masks the bit.
//   Reset mid-operation: all state returns to reset values immediately.
//     Priming restarts; pending edges are lost.
//   Writes to the data address never affect the captured or masked state.
// TESTING
//   1 Reset, then hold in_port=4'hF through and after reset release.
//     -> edge_capture stays 0 and irq stays 0. Read addr0 returns 0x0000000F.
//   2 EDGE_TYPE=0, in_port 0->4'b0101. -> edge_capture=0x5 exactly 3 clks later.
//     Later 0101->0000 -> edge_capture still 0x5.
//   3 Write mask=0x1 at addr2 and edge_capture=0x5. -> irq=1.
//     Write 0x1 to addr3 -> edge_capture=0x4, irq=0 next clk.
//   4 Write 0x4 to addr3 in the same cycle a new rising edge on bit2 is detected.
//     -> bit2 remains 1.
//   5 EDGE_TYPE=2: toggle bit1 twice. -> bit1 set after the first toggle.
//     Clear it; the second toggle sets it again. Read back at addr3 = 0x2 with 1-clk latency.
//   6 Assert reset_n low mid-capture with mask=0xF and irq=1.
//     -> irq, mask and capture = 0 asynchronously. Priming repeats after release.

Source files
------------

// File: rtl/sd_dat_in_pio.sv
// Avalon-MM input PIO for SD card DAT/CMD read-back: synchronises the pads, captures
// edges in a sticky write-1-to-clear register and raises a maskable level interrupt.
module sd_dat_in_pio #(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int CNT_W     = $clog2(PRIME_MAX + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  s;
    logic [WIDTH-1:0]                  prev;
    logic [CNT_W-1:0]                  prime_cnt;
    logic                              primed;
    logic [WIDTH-1:0]                  edge_raw;
    logic [WIDTH-1:0]                  det;
    logic [WIDTH-1:0]                  irq_mask;
    logic [WIDTH-1:0]                  edge_capture;
    logic [WIDTH-1:0]                  wd;
    logic                              wr_en;
    logic [31:0]                       read_mux;

    assign s      = sync_q[SYNC_STAGES-1];
    assign wd     = writedata[WIDTH-1:0];
    assign wr_en  = chipselect & ~write_n;
    assign primed = (prime_cnt == CNT_W'(PRIME_MAX));

    generate
        if (WIDTH < 32) begin : g_unused_wd
            logic unused_wd;
            assign unused_wd = ^writedata[31:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev   <= s;
        end
    end

    // Edges are ignored until the chain and prev hold real pad samples, so a pad
    // that is already high at reset release never looks like a rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= '0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + 1'b1;
        end
    end

    always_comb begin
        edge_raw = s & ~prev;
        case (EDGE_TYPE)
            1:       edge_raw = ~s & prev;
            2:       edge_raw = s ^ prev;
            default: edge_raw = s & ~prev;
        endcase
        det = primed ? edge_raw : '0;
    end

    // A clear and a new edge on the same bit in one cycle leaves the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
            irq_mask     <= '0;
        end else begin
            if (wr_en && address == 2'd3) begin
                edge_capture <= (edge_capture & ~wd) | det;
            end else begin
                edge_capture <= edge_capture | det;
            end
            if (wr_en && address == 2'd2) begin
                irq_mask <= wd;
            end
        end
    end

    always_comb begin
        read_mux = '0;
        case (address)
            2'd0:    read_mux[WIDTH-1:0] = s;
            2'd2:    read_mux[WIDTH-1:0] = irq_mask;
            2'd3:    read_mux[WIDTH-1:0] = edge_capture;
            default: read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= read_mux;
            irq      <= |(edge_capture & irq_mask);
        end
    end

endmodule

// File: tb/tb_sd_dat_in_pio.sv
// Directed bench for sd_dat_in_pio: one instance per edge type sharing the Avalon bus,
// each with its own pad inputs, readdata and irq.
module tb_sd_dat_in_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port0, in_port1, in_port2;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int checks = 0;
    int errors = 0;

    sd_dat_in_pio #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port0),
        .readdata(rd0), .irq(irq0)
    );

    sd_dat_in_pio #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port1),
        .readdata(rd1), .irq(irq1)
    );

    sd_dat_in_pio #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port2),
        .readdata(rd2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic do_read(input logic [1:0] a);
        @(negedge clk);
        address = a;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (rd0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_readdata: got %h want 00000000", rd0); end
        checks++; if (irq0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b want 0", irq0); end
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        do_read(2'd3);
        checks++; if (rd0 !== 32'h0) begin errors++; $display("[TB] FAIL prime_rise_cap: got %h want 00000000", rd0); end
        checks++; if (rd1 !== 32'h0) begin errors++; $display("[TB] FAIL prime_fall_cap: got %h want 00000000", rd1); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("[TB] FAIL prime_any_cap: got %h want 00000000", rd2); end
        checks++; if (irq0 !== 1'b0) begin errors++; $display("[TB] FAIL prime_irq: got %b want 0", irq0); end
        do_read(2'd0);
        checks++; if (rd0 !== 32'h0000000F) begin errors++; $display("[TB] FAIL data_read: got %h want 0000000F", rd0); end
    endtask

    task automatic test_rising;
        in_port0 = 4'b0000;
        repeat (6) @(negedge clk);
        do_read(2'd3);
        checks++; if (rd0 !== 32'h0) begin errors++; $display("[TB] FAIL rise_ignores_fall: got %h want 00000000", rd0); end
        in_port0 = 4'b0101;
        repeat (3) @(negedge clk);
        checks++; if (rd0 !== 32'h0) begin errors++; $display("[TB] FAIL rise_latency_early: got %h want 00000000", rd0); end
        @(negedge clk);
        checks++; if (rd0 !== 32'h5) begin errors++; $display("[TB] FAIL rise_latency: got %h want 00000005", rd0); end
        in_port0 = 4'b0000;
        repeat (5) @(negedge clk);
        checks++; if (rd0 !== 32'h5) begin errors++; $display("[TB] FAIL rise_sticky: got %h want 00000005", rd0); end
    endtask

    task automatic test_irq;
        do_write(2'd2, 32'h1);
        checks++; if (irq0 !== 1'b0) begin errors++; $display("[TB] FAIL irq_assert_early: got %b want 0", irq0); end
        @(negedge clk);
        checks++; if (irq0 !== 1'b1) begin errors++; $display("[TB] FAIL irq_assert: got %b want 1", irq0); end
        do_write(2'd3, 32'h1);
        checks++; if (irq0 !== 1'b1) begin errors++; $display("[TB] FAIL irq_clear_early: got %b want 1", irq0); end
        @(negedge clk);
        checks++; if (irq0 !== 1'b0) begin errors++; $display("[TB] FAIL irq_clear: got %b want 0", irq0); end
        do_read(2'd3);
        checks++; if (rd0 !== 32'h4) begin errors++; $display("[TB] FAIL w1c_bit0: got %h want 00000004", rd0); end
    endtask

    task automatic test_clear_collision;
        @(negedge clk);
        in_port0 = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        address    = 2'd3;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 32'h4;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        do_read(2'd3);
        checks++; if (rd0 !== 32'h4) begin errors++; $display("[TB] FAIL collision_edge_wins: got %h want 00000004", rd0); end
        do_write(2'd3, 32'h4);
        do_read(2'd3);
        checks++; if (rd0 !== 32'h0) begin errors++; $display("[TB] FAIL plain_clear: got %h want 00000000", rd0); end
    endtask

    task automatic test_any_edge;
        in_port2 = 4'b1101;
        repeat (5) @(negedge clk);
        do_read(2'd3);
        checks++; if (rd2 !== 32'h2) begin errors++; $display("[TB] FAIL any_first_toggle: got %h want 00000002", rd2); end
        do_write(2'd3, 32'h2);
        do_read(2'd3);
        checks++; if (rd2 !== 32'h0) begin errors++; $display("[TB] FAIL any_clear: got %h want 00000000", rd2); end
        in_port2 = 4'b1111;
        repeat (5) @(negedge clk);
        do_read(2'd0);
        checks++; if (rd2 !== 32'hF) begin errors++; $display("[TB] FAIL any_data: got %h want 0000000F", rd2); end
        address = 2'd3;
        #1;
        checks++; if (rd2 !== 32'hF) begin errors++; $display("[TB] FAIL read_latency_hold: got %h want 0000000F", rd2); end
        @(negedge clk);
        checks++; if (rd2 !== 32'h2) begin errors++; $display("[TB] FAIL any_second_toggle: got %h want 00000002", rd2); end
    endtask

    task automatic test_falling;
        in_port1 = 4'b0110;
        repeat (5) @(negedge clk);
        do_read(2'd3);
        checks++; if (rd1 !== 32'h9) begin errors++; $display("[TB] FAIL fall_capture: got %h want 00000009", rd1); end
        in_port1 = 4'b1111;
        repeat (5) @(negedge clk);
        do_read(2'd3);
        checks++; if (rd1 !== 32'h9) begin errors++; $display("[TB] FAIL fall_ignores_rise: got %h want 00000009", rd1); end
    endtask

    task automatic test_data_write;
        do_write(2'd2, 32'h3);
        do_write(2'd0, 32'hF);
        do_write(2'd1, 32'hF);
        do_read(2'd2);
        checks++; if (rd1 !== 32'h3) begin errors++; $display("[TB] FAIL mask_after_data_wr: got %h want 00000003", rd1); end
        do_read(2'd3);
        checks++; if (rd1 !== 32'h9) begin errors++; $display("[TB] FAIL cap_after_data_wr: got %h want 00000009", rd1); end
        checks++; if (rd2 !== 32'h2) begin errors++; $display("[TB] FAIL cap2_after_data_wr: got %h want 00000002", rd2); end
        do_read(2'd1);
        checks++; if (rd1 !== 32'h0) begin errors++; $display("[TB] FAIL addr1_read: got %h want 00000000", rd1); end
        do_write(2'd2, 32'hFFFF_FFF0);
        do_read(2'd2);
        checks++; if (rd1 !== 32'h0) begin errors++; $display("[TB] FAIL mask_upper_ignored: got %h want 00000000", rd1); end
    endtask

    task automatic test_reset_mid;
        do_write(2'd2, 32'hF);
        @(negedge clk);
        checks++; if (irq1 !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_irq1: got %b want 1", irq1); end
        checks++; if (irq2 !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_irq2: got %b want 1", irq2); end
        in_port0 = 4'b0101;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (irq1 !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_irq1: got %b want 0", irq1); end
        checks++; if (irq2 !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_irq2: got %b want 0", irq2); end
        checks++; if (rd1 !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_rd: got %h want 00000000", rd1); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        do_read(2'd3);
        checks++; if (rd0 !== 32'h0) begin errors++; $display("[TB] FAIL pending_lost: got %h want 00000000", rd0); end
        checks++; if (rd1 !== 32'h0) begin errors++; $display("[TB] FAIL cap_after_reset: got %h want 00000000", rd1); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("[TB] FAIL cap2_after_reset: got %h want 00000000", rd2); end
        do_read(2'd2);
        checks++; if (rd1 !== 32'h0) begin errors++; $display("[TB] FAIL mask_after_reset: got %h want 00000000", rd1); end
        checks++; if (irq1 !== 1'b0) begin errors++; $display("[TB] FAIL irq_after_reset: got %b want 0", irq1); end
        do_read(2'd3);
        in_port1 = 4'b1110;
        repeat (3) @(negedge clk);
        checks++; if (rd1 !== 32'h0) begin errors++; $display("[TB] FAIL post_reset_edge_early: got %h want 00000000", rd1); end
        @(negedge clk);
        checks++; if (rd1 !== 32'h1) begin errors++; $display("[TB] FAIL post_reset_edge: got %h want 00000001", rd1); end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port0   = 4'hF;
        in_port1   = 4'hF;
        in_port2   = 4'hF;
        test_reset();
        test_rising();
        test_irq();
        test_clear_collision();
        test_any_edge();
        test_falling();
        test_data_write();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
